// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO controller slice.
package fifo_pkg;

    localparam int unsigned DEF_RAM_WIDTH = 10;
    localparam int unsigned DEF_RAM_DEPTH = 8;
    localparam int unsigned DEF_ADDR_SIZE = 3;
    localparam int unsigned DEF_AF_THRESH = 6;
    localparam int unsigned DEF_AE_THRESH = 2;

    // Pointer carries one extra wrap bit above the RAM address.
    typedef logic [DEF_ADDR_SIZE:0] ptr_t;

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer side of the FIFO controller: requests, read data, status.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) ();

    logic                 push;
    logic [RAM_WIDTH-1:0] push_data;
    logic                 pop;
    logic [RAM_WIDTH-1:0] pop_data;
    logic                 pop_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output push, push_data, pop,
        input  pop_data, pop_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, push_data, pop,
        output pop_data, pop_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: increments by one when enabled, wraps modulo its width.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter type PTR_T = ptr_t
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output PTR_T ptr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_T'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller driving an external dual-port RAM with
// registered read; keeps occupancy, full/empty, almost thresholds and error pulses.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int unsigned AF_THRESH = DEF_AF_THRESH,
    parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_if.slave                bus,
    output logic                 mem_wr_enb,
    output logic [ADDR_SIZE-1:0] mem_wr_addr,
    output logic [RAM_WIDTH-1:0] mem_data_in,
    output logic                 mem_rd_enb,
    output logic [ADDR_SIZE-1:0] mem_rd_addr,
    input  logic [RAM_WIDTH-1:0] mem_data_out
);

    typedef logic [ADDR_SIZE:0] cnt_t;

    cnt_t wr_ptr;
    cnt_t rd_ptr;
    cnt_t count_q;
    cnt_t count_nxt;

    logic full_q;
    logic empty_q;
    logic af_q;
    logic ae_q;
    logic pop_valid_q;
    logic ovf_q;
    logic unf_q;

    logic push_acc;
    logic pop_acc;

    // Accept decisions use the flags registered last cycle, never the next count.
    always_comb begin
        push_acc = bus.push & ~full_q;
        pop_acc  = bus.pop  & ~empty_q;
    end

    fifo_ptr #(.PTR_T(cnt_t)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.PTR_T(cnt_t)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_nxt = count_q;
        unique case ({push_acc, pop_acc})
            2'b10:   count_nxt = count_q + cnt_t'(1);
            2'b01:   count_nxt = count_q - cnt_t'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_q     <= count_nxt;
            full_q      <= (count_nxt == cnt_t'(RAM_DEPTH));
            empty_q     <= (count_nxt == '0);
            af_q        <= (count_nxt >= cnt_t'(AF_THRESH));
            ae_q        <= (count_nxt <= cnt_t'(AE_THRESH));
            pop_valid_q <= pop_acc;
            ovf_q       <= bus.push & full_q;
            unf_q       <= bus.pop & empty_q;
        end
    end

    always_comb begin
        mem_wr_enb  = push_acc;
        mem_wr_addr = wr_ptr[ADDR_SIZE-1:0];
        mem_data_in = bus.push_data;
        mem_rd_enb  = pop_acc;
        mem_rd_addr = rd_ptr[ADDR_SIZE-1:0];
    end

    assign bus.pop_data     = mem_data_out;
    assign bus.pop_valid    = pop_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

    // Wrap-bit pointer distance must always agree with the tracked occupancy.
    a_ptr_count: assert property (@(posedge clk) disable iff (!rst)
        cnt_t'(wr_ptr - rd_ptr) == count_q);

    a_count_range: assert property (@(posedge clk) disable iff (!rst)
        count_q <= cnt_t'(RAM_DEPTH));

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model, with a registered-read RAM attached.
module tb_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       mem_wr_enb;
    logic [2:0] mem_wr_addr;
    logic [9:0] mem_data_in;
    logic       mem_rd_enb;
    logic [2:0] mem_rd_addr;
    logic [9:0] mem_data_out;

    fifo_if #(.RAM_WIDTH(10), .ADDR_SIZE(3)) bus ();

    fifo_ctrl #(
        .RAM_WIDTH (10),
        .RAM_DEPTH (8),
        .ADDR_SIZE (3),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_wr_enb   (mem_wr_enb),
        .mem_wr_addr  (mem_wr_addr),
        .mem_data_in  (mem_data_in),
        .mem_rd_enb   (mem_rd_enb),
        .mem_rd_addr  (mem_rd_addr),
        .mem_data_out (mem_data_out)
    );

    // Dual-port RAM with registered read
    logic [9:0] ram [8];
    logic [9:0] ram_q;
    always @(posedge clk) begin
        if (mem_wr_enb) ram[mem_wr_addr] <= mem_data_in;
        if (mem_rd_enb) ram_q <= ram[mem_rd_addr];
    end
    assign mem_data_out = ram_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model: FIFO contents plus counts of accepted transfers
    logic [9:0]  q [$];
    int unsigned wr_cnt;
    int unsigned rd_cnt;

    // Observed pre-edge RAM drive and the expectations for it
    logic       o_wr_enb, o_rd_enb;
    logic [2:0] o_wr_addr, o_rd_addr;
    logic [9:0] o_din;
    logic       x_wr_enb, x_rd_enb;
    logic [2:0] x_wr_addr, x_rd_addr;
    logic [9:0] x_din;
    // Expected post-edge outputs
    logic       e_ovf, e_unf, e_pv;
    logic [9:0] e_pd;

    task automatic model_clear();
        q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic apply_reset();
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.push_data = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        model_clear();
    endtask

    // Drive one cycle of requests, capture RAM drive before the edge, advance model.
    task automatic cycle(input logic p, input logic [9:0] d, input logic r);
        bit pa;
        bit ra;
        bus.push      = p;
        bus.push_data = d;
        bus.pop       = r;
        #1;
        o_wr_enb  = mem_wr_enb;
        o_wr_addr = mem_wr_addr;
        o_din     = mem_data_in;
        o_rd_enb  = mem_rd_enb;
        o_rd_addr = mem_rd_addr;
        pa = p && (q.size() < 8);
        ra = r && (q.size() != 0);
        x_wr_enb  = pa;
        x_rd_enb  = ra;
        x_wr_addr = 3'(wr_cnt % 8);
        x_rd_addr = 3'(rd_cnt % 8);
        x_din     = d;
        e_ovf = p && (q.size() == 8);
        e_unf = r && (q.size() == 0);
        e_pv  = ra;
        if (ra) begin
            e_pd = q.pop_front();
            rd_cnt++;
        end
        if (pa) begin
            q.push_back(d);
            wr_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_almost_empty: got %b want 1", bus.almost_empty); end
        n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_vec++; if (bus.almost_full !== 1'b0) begin n_err++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
        n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL reset_pop_valid: got %b want 0", bus.pop_valid); end
        n_vec++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_err++; $display("FAIL reset_errors: got %b%b want 00", bus.overflow, bus.underflow); end
        n_vec++; if ({mem_wr_enb, mem_rd_enb} !== 2'b00) begin n_err++; $display("FAIL reset_mem_enb: got %b%b want 00", mem_wr_enb, mem_rd_enb); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 10'(i + 1), 1'b0);
            n_vec++; if (o_wr_enb !== 1'b1) begin n_err++; $display("FAIL fill_wr_enb[%0d]: got %b want 1", i, o_wr_enb); end
            n_vec++; if (o_wr_addr !== 3'(i)) begin n_err++; $display("FAIL fill_wr_addr[%0d]: got %0d want %0d", i, o_wr_addr, i); end
            n_vec++; if (bus.count !== 4'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1); end
            n_vec++; if (bus.almost_full !== (i + 1 >= 6)) begin n_err++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, bus.almost_full, (i + 1 >= 6)); end
            n_vec++; if (bus.full !== (i == 7)) begin n_err++; $display("FAIL fill_full[%0d]: got %b want %b", i, bus.full, (i == 7)); end
        end
        cycle(1'b1, 10'h0FF, 1'b0);
        n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow: got %b want 1", bus.overflow); end
        n_vec++; if (o_wr_enb !== 1'b0) begin n_err++; $display("FAIL fill_rejected_wr_enb: got %b want 0", o_wr_enb); end
        n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL fill_count_held: got %0d want 8", bus.count); end
        cycle(1'b0, 10'h000, 1'b0);
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL fill_overflow_pulse: got %b want 0", bus.overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 10'h000, 1'b1);
            n_vec++; if (bus.pop_valid !== 1'b1) begin n_err++; $display("FAIL drain_pop_valid[%0d]: got %b want 1", i, bus.pop_valid); end
            n_vec++; if (bus.pop_data !== 10'(i + 1)) begin n_err++; $display("FAIL drain_pop_data[%0d]: got %h want %h", i, bus.pop_data, 10'(i + 1)); end
            n_vec++; if (bus.count !== 4'(7 - i)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count, 7 - i); end
        end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b want 1", bus.empty); end
        cycle(1'b0, 10'h000, 1'b1);
        n_vec++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL drain_underflow: got %b want 1", bus.underflow); end
        n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL drain_rejected_pop_valid: got %b want 0", bus.pop_valid); end
        n_vec++; if (o_rd_enb !== 1'b0) begin n_err++; $display("FAIL drain_rejected_rd_enb: got %b want 0", o_rd_enb); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cycle(1'b1, 10'h011, 1'b0);
        cycle(1'b1, 10'h022, 1'b0);
        cycle(1'b1, 10'h033, 1'b0);
        cycle(1'b1, 10'h0CC, 1'b1);
        n_vec++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL simul_mid_count: got %0d want 3", bus.count); end
        n_vec++; if (bus.pop_data !== 10'h011 || bus.pop_valid !== 1'b1) begin n_err++; $display("FAIL simul_mid_data: got %b/%h want 1/011", bus.pop_valid, bus.pop_data); end
        repeat (3) cycle(1'b0, 10'h000, 1'b1);
        cycle(1'b1, 10'h0AA, 1'b1);
        n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL simul_empty_count: got %0d want 1", bus.count); end
        n_vec++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL simul_empty_underflow: got %b want 1", bus.underflow); end
        n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty_pop_valid: got %b want 0", bus.pop_valid); end
        for (int i = 0; i < 7; i++) cycle(1'b1, 10'(10'h100 + i), 1'b0);
        n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL simul_full_flag: got %b want 1", bus.full); end
        cycle(1'b1, 10'h055, 1'b1);
        n_vec++; if (bus.count !== 4'd7) begin n_err++; $display("FAIL simul_full_count: got %0d want 7", bus.count); end
        n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL simul_full_overflow: got %b want 1", bus.overflow); end
        n_vec++; if (bus.pop_data !== 10'h0AA || bus.pop_valid !== 1'b1) begin n_err++; $display("FAIL simul_full_data: got %b/%h want 1/0aa", bus.pop_valid, bus.pop_data); end
    endtask

    task automatic test_wrap();
        int unsigned exp_addr [6] = '{5, 6, 7, 0, 1, 2};
        logic [9:0]  vals [6];
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 10'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 10'h000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            vals[i] = 10'($urandom);
            cycle(1'b1, vals[i], 1'b0);
            n_vec++; if (o_wr_addr !== 3'(exp_addr[i])) begin n_err++; $display("FAIL wrap_wr_addr[%0d]: got %0d want %0d", i, o_wr_addr, exp_addr[i]); end
        end
        n_vec++; if (bus.count !== 4'd6) begin n_err++; $display("FAIL wrap_count: got %0d want 6", bus.count); end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 10'h000, 1'b1);
            n_vec++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== vals[i]) begin n_err++; $display("FAIL wrap_readback[%0d]: got %b/%h want 1/%h", i, bus.pop_valid, bus.pop_data, vals[i]); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 10'(10'h040 + i), 1'b0);
        cycle(1'b0, 10'h000, 1'b1);
        n_vec++; if (bus.pop_valid !== 1'b1 || bus.count !== 4'd4) begin n_err++; $display("FAIL midrst_setup: got %b/%0d want 1/4", bus.pop_valid, bus.count); end
        #3;
        rst = 1'b0;
        #1;
        n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
        n_vec++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL midrst_pop_valid: got %b want 0", bus.pop_valid); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL midrst_empty: got %b want 1", bus.empty); end
        #2;
        rst = 1'b1;
        model_clear();
        cycle(1'b1, 10'h123, 1'b0);
        n_vec++; if (o_wr_enb !== 1'b1 || o_wr_addr !== 3'd0) begin n_err++; $display("FAIL midrst_first_write: got %b@%0d want 1@0", o_wr_enb, o_wr_addr); end
        n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL midrst_after_count: got %0d want 1", bus.count); end
    endtask

    task automatic test_random();
        int unsigned pp;
        logic p, r;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            pp = ((i / 100) % 2 == 0) ? 70 : 30;
            p = ($urandom_range(99) < pp);
            r = ($urandom_range(99) < (100 - pp));
            cycle(p, 10'($urandom), r);
            n_vec++; if (int'(bus.count) != q.size()) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.count, q.size()); end
            n_vec++; if ({bus.full, bus.empty} !== {q.size() == 8, q.size() == 0}) begin n_err++; $display("FAIL rnd_full_empty[%0d]: got %b%b want %b%b", i, bus.full, bus.empty, q.size() == 8, q.size() == 0); end
            n_vec++; if ({bus.almost_full, bus.almost_empty} !== {q.size() >= 6, q.size() <= 2}) begin n_err++; $display("FAIL rnd_almost[%0d]: got %b%b want %b%b", i, bus.almost_full, bus.almost_empty, q.size() >= 6, q.size() <= 2); end
            n_vec++; if ({bus.overflow, bus.underflow} !== {e_ovf, e_unf}) begin n_err++; $display("FAIL rnd_errors[%0d]: got %b%b want %b%b", i, bus.overflow, bus.underflow, e_ovf, e_unf); end
            n_vec++; if (bus.pop_valid !== e_pv) begin n_err++; $display("FAIL rnd_pop_valid[%0d]: got %b want %b", i, bus.pop_valid, e_pv); end
            if (e_pv) begin
                n_vec++; if (bus.pop_data !== e_pd) begin n_err++; $display("FAIL rnd_pop_data[%0d]: got %h want %h", i, bus.pop_data, e_pd); end
            end
            n_vec++; if ({o_wr_enb, o_rd_enb} !== {x_wr_enb, x_rd_enb}) begin n_err++; $display("FAIL rnd_mem_enb[%0d]: got %b%b want %b%b", i, o_wr_enb, o_rd_enb, x_wr_enb, x_rd_enb); end
            if (x_wr_enb) begin
                n_vec++; if (o_wr_addr !== x_wr_addr || o_din !== x_din) begin n_err++; $display("FAIL rnd_write[%0d]: got %h@%0d want %h@%0d", i, o_din, o_wr_addr, x_din, x_wr_addr); end
            end
            if (x_rd_enb) begin
                n_vec++; if (o_rd_addr !== x_rd_addr) begin n_err++; $display("FAIL rnd_rd_addr[%0d]: got %0d want %0d", i, o_rd_addr, x_rd_addr); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit 200000 reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.push_data = '0;
        model_clear();
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the dual-port RAM write/read interface (wr_enb, rd_enb, wr_addr, rd_addr, data_in, data_out).
- Turns push/pop requests into RAM accesses through wrapping pointers, and keeps occupancy, full/empty and almost-thresholds.
- Error pulses mark overflow and underflow.
- Sits between a producer/consumer pair and one dual-port RAM instance, replacing hand-driven RAM addressing.

Parameters:
RAM_WIDTH, 10, data word width
RAM_DEPTH, 8, FIFO depth in words; must equal 2**ADDR_SIZE
ADDR_SIZE, 3, RAM address width
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
push  input  1  write request
push_data  input  RAM_WIDTH  write data
pop  input  1  read request
pop_data  output  RAM_WIDTH  read data; valid when pop_valid=1
pop_valid  output  1  read data valid, one cycle after an accepted pop
full  output  1  count == RAM_DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  ADDR_SIZE+1  occupancy, 0..RAM_DEPTH
overflow  output  1  one-cycle pulse: push rejected
underflow  output  1  one-cycle pulse: pop rejected
mem_wr_enb  output  1  to RAM wr_enb
mem_wr_addr  output  ADDR_SIZE  to RAM wr_addr
mem_data_in  output  RAM_WIDTH  to RAM data_in
mem_rd_enb  output  1  to RAM rd_enb
mem_rd_addr  output  ADDR_SIZE  to RAM rd_addr
mem_data_out  input  RAM_WIDTH  from RAM data_out; registered read, valid 1 cycle after rd_enb

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, pop_valid=0, overflow=0, underflow=0. RAM contents are not cleared.
- Pointers: wr_ptr and rd_ptr are ADDR_SIZE+1 bits. The MSB is the wrap bit. The low ADDR_SIZE bits go to the RAM addresses. Wrap is natural modulo 2**(ADDR_SIZE+1).
- Accept rules: push_acc = push & ~full; pop_acc = pop & ~empty. Both are evaluated on the registered flags of the current cycle.
- RAM drive is combinational from the accept terms:
  - mem_wr_enb=push_acc, mem_wr_addr=wr_ptr[ADDR_SIZE-1:0], mem_data_in=push_data.
  - mem_rd_enb=pop_acc, mem_rd_addr=rd_ptr[ADDR_SIZE-1:0].
- On a clk edge: wr_ptr += push_acc; rd_ptr += pop_acc; count += push_acc - pop_acc. All flags are registered from the next count.
- Read latency: pop_valid <= pop_acc. pop_data = mem_data_out passthrough, so data appears in the cycle after pop.
- Simultaneous push and pop:
  - Neither full nor empty: both accepted, count unchanged.
  - Empty: push accepted, pop rejected, underflow pulses.
  - Full: pop accepted, push rejected, overflow pulses.
  - Write-then-read of the same address is never issued in one cycle, because the empty rule prevents it.
- Errors: overflow <= push & full; underflow <= pop & empty. Each is a single-cycle pulse per rejected request. Pointers and count are unchanged by a rejected request.
- Reset mid-operation: all state returns to reset values immediately. A pop_valid pending from the previous cycle is dropped (pop_valid=0).
- count never exceeds RAM_DEPTH and never goes below 0.

Decomposition:
- Shared package fifo_pkg holds:
  - default RAM_WIDTH, RAM_DEPTH, ADDR_SIZE, AF_THRESH, AE_THRESH;
  - a ptr_t typedef of width ADDR_SIZE+1.
- Natural sub-module: fifo_ptr, one instance per pointer. It holds the pointer register, an increment enable and an async active-low reset.
- Flag logic and RAM drive stay in fifo_ctrl.

Test Plan:
- Reset: rst=0 for 2 cycles then 1 -> count=0, empty=1, almost_empty=1, full=0, pop_valid=0, no mem_wr_enb/mem_rd_enb.
- Fill: 8 pushes of 0x001..0x008 -> mem_wr_addr 0..7, count reaches 8, almost_full at count=6, full=1. A 9th push 0x0FF -> overflow pulse, mem_wr_enb=0, count stays 8.
- Drain: 8 pops -> pop_data 0x001..0x008 in order, each one cycle after pop with pop_valid=1, empty=1 at end. A 9th pop -> underflow pulse, pop_valid=0.
- Simultaneous: at count=3, push 0x0CC and pop together -> count stays 3. At empty, push and pop together -> count=1, underflow=1. At full, push and pop together -> count=7, overflow=1.
- Wrap-around: push 5, pop 5, push 6 -> mem_wr_addr sequence 5,6,7,0,1,2, count=6, and FIFO order is preserved on readback.
- Reset mid-operation: count=4 with a pop in flight, assert rst=0 asynchronously between edges -> count=0, pop_valid=0 immediately. Next push writes mem_wr_addr=0.
